// File: rtl/sr_reg_monitor.sv
// ---------------------------------------------------------------------------
// sr_reg_monitor
//
// Purpose:
//   Watches one sr_cpu register through the CPU's debug port. An event is
//   queued whenever the register value changes, and also for the first sample
//   after reset. Each event carries {value, pc, cycle stamp}. Events go into a
//   small FIFO that a consumer drains with a valid/ready handshake. A sticky
//   overflow flag and a saturating counter record the events that were
//   dropped. As a build option, a pass detector flags the first cycle in which
//   the register equals one of two known-good results.
//
// Build option:
//   SR_REG_MONITOR_MATCH_EN  defined   -> pass / pass_cycle are driven by a
//                                         comparator against MATCH0 / MATCH1.
//                            undefined -> pass / pass_cycle are tied to 0.
//                                         No comparator is built.
//
// Parameters:
//   WATCH_REG  register index driven on regAddr.
//   DEPTH      number of event FIFO entries. Power of two, 2..16.
//   MATCH0/1   register values that count as a pass.
//
// Ports:
//   clk         single clock. All state updates on posedge.
//   rst         synchronous, active-high reset.
//   regAddr     debug register address to sr_cpu. Always WATCH_REG.
//   regData     debug register data from sr_cpu.
//   imAddr      current instruction address. Captured with each event.
//   evt_valid   FIFO head holds an event.
//   evt_ready   consumer accepts the head event.
//   evt_value   register value of the head event. 0 when the FIFO is empty.
//   evt_pc      imAddr of the head event. 0 when the FIFO is empty.
//   evt_cycle   cycle stamp of the head event. 0 when the FIFO is empty.
//   overflow    sticky: at least one event was dropped.
//   drop_cnt    number of dropped events. Saturates at 8'hFF.
//   pass        sticky: the register matched MATCH0 or MATCH1.
//   pass_cycle  cycle stamp at which pass first set.
//
// Handshake:
//   A pop happens on a posedge where evt_valid && evt_ready.
//   evt_valid depends only on FIFO state, never on evt_ready.
//   The head payload stays stable while evt_valid && !evt_ready.
//   evt_ready is ignored while the FIFO is empty.
// ---------------------------------------------------------------------------
module sr_reg_monitor #(
  parameter logic [4:0]  WATCH_REG = 5'd10,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] MATCH0    = 32'h00213d05,
  parameter logic [31:0] MATCH1    = 32'h1c8cfc00
) (
  input  logic        clk,
  input  logic        rst,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  input  logic [31:0] imAddr,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [31:0] evt_value,
  output logic [31:0] evt_pc,
  output logic [15:0] evt_cycle,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic        pass,
  output logic [15:0] pass_cycle
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Free-running cycle stamp and change detector state.
  logic [15:0] r_cycle;
  logic [31:0] r_prev_value;
  logic        r_prev_ok;

  // FIFO storage.
  // The pointers carry one extra wrap bit so that full and empty can be told
  // apart.
  logic [31:0] r_mem_value [DEPTH];
  logic [31:0] r_mem_pc    [DEPTH];
  logic [15:0] r_mem_cycle [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic        r_overflow;
  logic [7:0]  r_drop_cnt;

  logic w_evt;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign regAddr = WATCH_REG;

  assign w_evt   = !r_prev_ok || (regData != r_prev_value);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = w_evt && (!w_full || w_pop);
  assign w_drop  = w_evt && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle      <= 16'd0;
      r_prev_value <= 32'd0;
      r_prev_ok    <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= 8'd0;
    end else begin
      r_cycle      <= r_cycle + 16'd1;
      r_prev_value <= regData;
      r_prev_ok    <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  // The payload RAM needs no reset. Reads of stale entries are masked by
  // w_empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_value[r_wr_ptr[AW-1:0]] <= regData;
      r_mem_pc[r_wr_ptr[AW-1:0]]    <= imAddr;
      r_mem_cycle[r_wr_ptr[AW-1:0]] <= r_cycle;
    end
  end

  assign evt_valid = !w_empty;
  assign evt_value = w_empty ? 32'd0 : r_mem_value[r_rd_ptr[AW-1:0]];
  assign evt_pc    = w_empty ? 32'd0 : r_mem_pc[r_rd_ptr[AW-1:0]];
  assign evt_cycle = w_empty ? 16'd0 : r_mem_cycle[r_rd_ptr[AW-1:0]];
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

`ifdef SR_REG_MONITOR_MATCH_EN
  logic        r_pass;
  logic [15:0] r_pass_cycle;
  logic        w_match;

  assign w_match = (regData == MATCH0) || (regData == MATCH1);

  // pass_cycle is loaded only on the first match. Later matches leave it
  // alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass       <= 1'b0;
      r_pass_cycle <= 16'd0;
    end else if (w_match && !r_pass) begin
      r_pass       <= 1'b1;
      r_pass_cycle <= r_cycle;
    end
  end

  assign pass       = r_pass;
  assign pass_cycle = r_pass_cycle;
`else
  assign pass       = 1'b0;
  assign pass_cycle = 16'd0;
`endif

endmodule

// File: doc/sr_reg_monitor.md
SR_REG_MONITOR -- requirements
Module: sr_reg_monitor

Interface
REQ-001 Parameter WATCH_REG, default 5'd10, register index driven on regAddr (a0).
REQ-002 Parameter DEPTH, default 4, event FIFO entries, power of two, 2..16.
REQ-003 Parameter MATCH0, default 32'h00213d05, first pass value (Fibonacci).
REQ-004 Parameter MATCH1, default 32'h1c8cfc00, second pass value (Factorial).
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 regAddr  output  5  debug register address to sr_cpu; constant WATCH_REG.
REQ-008 regData  input  32  debug register data from sr_cpu.
REQ-009 imAddr  input  32  current instruction address from sr_cpu, captured with each event.
REQ-010 evt_valid  output  1  FIFO head holds an event.
REQ-011 evt_ready  input  1  consumer accepts head event.
REQ-012 evt_value  output  32  watched-register value of head event.
REQ-013 evt_pc  output  32  imAddr sampled with head event.
REQ-014 evt_cycle  output  16  cycle stamp of head event.
REQ-015 overflow  output  1  sticky: at least one event dropped.
REQ-016 drop_cnt  output  8  number of dropped events, saturating.
REQ-017 pass  output  1  sticky: watched register equalled MATCH0 or MATCH1.
REQ-018 pass_cycle  output  16  cycle stamp at which pass first set.

Function
REQ-019 regAddr SHALL equal WATCH_REG at all times, including during reset.
REQ-020 cycle counter SHALL be 16 bits, 0 in the first non-reset cycle, +1 per non-reset cycle, wrapping 16'hFFFF -> 16'h0000.
REQ-021 Module SHALL register regData each non-reset cycle as prev_value and set a prev_ok flag.
REQ-022 An event SHALL be generated in a non-reset cycle when prev_ok is 0 (first sample after reset) or regData != prev_value.
REQ-023 Event payload SHALL be {regData, imAddr, cycle counter} of the generating cycle.
REQ-024 Event generated in cycle N SHALL be visible at the FIFO output (evt_valid=1 if FIFO was empty) in cycle N+1.
REQ-025 evt_valid SHALL be 1 iff FIFO non-empty; evt_value/evt_pc/evt_cycle SHALL reflect the head entry, stable while evt_valid && !evt_ready.
REQ-026 Pop SHALL occur on posedge when evt_valid && evt_ready; evt_ready while empty SHALL be ignored.
REQ-027 Push with FIFO full and simultaneous pop SHALL succeed with no drop.
REQ-028 Push with FIFO full and no pop SHALL discard the new event, set overflow, increment drop_cnt saturating at 8'hFF.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit or occupancy counter.
REQ-030 pass logic per Configuration; when pass first sets, pass_cycle SHALL capture the cycle counter; later matches SHALL NOT change pass_cycle.

Reset
REQ-031 While rst=1 at posedge: FIFO emptied, cycle=0, prev_ok=0, prev_value=0, overflow=0, drop_cnt=0, pass=0, pass_cycle=0.
REQ-032 Outputs during and after reset until first event: evt_valid=0, evt_value=0, evt_pc=0, evt_cycle=0.
REQ-033 Reset asserted mid-operation SHALL discard all queued events and any push or pop of that cycle.

Configuration
REQ-034 Macro SR_REG_MONITOR_MATCH_EN: defined -> pass sets on any non-reset cycle with regData == MATCH0 or regData == MATCH1; comparator and pass_cycle register present.
REQ-035 Macro SR_REG_MONITOR_MATCH_EN undefined -> pass and pass_cycle tied to 0, no comparator logic; event FIFO behaviour unchanged.

Verification
REQ-036 Reset 2 cycles, regData held 32'h0, evt_ready=1 -> exactly one event {value 0, cycle 0}, evt_valid high one cycle only, no further events.
REQ-037 regData steps 0,1,1,2,3,5 on consecutive cycles, evt_ready=1 -> events with values 0,1,2,3,5 and cycle stamps 0,1,3,4,5, each one cycle after its change.
REQ-038 DEPTH=4, evt_ready=0, regData changes on 6 consecutive cycles -> 4 events queued, overflow=1, drop_cnt=2; then evt_ready=1 drains the 4 oldest in order.
REQ-039 FIFO full, change with simultaneous pop -> no drop, occupancy stays 4, drop_cnt unchanged.
REQ-040 Macro defined, regData reaches 32'h1c8cfc00 at cycle 37 -> pass=1 from cycle 38, pass_cycle=37; macro undefined same stimulus -> pass=0.
REQ-041 3 events queued, rst pulsed 1 cycle -> evt_valid=0, overflow=0, drop_cnt=0, next sample produces first-sample event with cycle 0.
